// File: rtl/trackball_quad_decoder.sv
// Trackball dir/clk receiver: synchronise, glitch-filter and count steps per axis.
// Optional TRACKBALL_PERIOD_EN adds per-axis step-period outputs.

module trackball_qd_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], d};

  if (FILTER_LEN == 0) begin : g_bypass
    assign q = sync[SYNC_STAGES-1];
  end else begin : g_filt
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [CW-1:0] cnt;
    logic          filt;

    // A change is accepted only after it has persisted FILTER_LEN cycles.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt  <= '0;
        filt <= 1'b0;
      end else if (sync[SYNC_STAGES-1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[SYNC_STAGES-1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

    assign q = filt;
  end
endmodule

module trackball_qd_axis #(
  parameter logic [19:0] IDLE_TIMEOUT   = 20'd600000,
  parameter int          CLEAR_ON_LATCH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dir_f,
  input  logic        clk_f,
  input  logic        latch,
  output logic [7:0]  count,
  output logic        step,
  output logic        active
`ifdef TRACKBALL_PERIOD_EN
  ,
  output logic [15:0] period
`endif
);
  typedef enum logic {IDLE, ACTIVE} act_t;

  localparam bit CLR = (CLEAR_ON_LATCH != 0);

  act_t        state;
  logic        clk_d, dir_d, rise, going_idle;
  logic [7:0]  pos, pos_step;
  logic [19:0] idle_cnt;

  // Delayed dir keeps a same-cycle dir change from steering this step.
  assign rise       = clk_f & ~clk_d;
  assign pos_step   = dir_d ? pos + 8'd1 : pos - 8'd1;
  assign going_idle = (state == ACTIVE) && !rise && (idle_cnt <= 20'd1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      clk_d    <= 1'b0;
      dir_d    <= 1'b0;
      step     <= 1'b0;
      pos      <= '0;
      count    <= '0;
      state    <= IDLE;
      active   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      clk_d <= clk_f;
      dir_d <= dir_f;
      step  <= rise;
      if (latch) count <= pos;
      if (latch && CLR)  pos <= rise ? (dir_d ? 8'd1 : 8'hFF) : 8'd0;
      else if (rise)     pos <= pos_step;

      case (state)
        IDLE: if (rise) begin
          state    <= ACTIVE;
          active   <= 1'b1;
          idle_cnt <= IDLE_TIMEOUT;
        end
        ACTIVE: if (rise) begin
          idle_cnt <= IDLE_TIMEOUT;
        end else if (going_idle) begin
          state    <= IDLE;
          active   <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt - 20'd1;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end

`ifdef TRACKBALL_PERIOD_EN
  logic [15:0] per_cnt;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      per_cnt <= '0;
      period  <= '0;
    end else if (rise) begin
      period  <= per_cnt;
      per_cnt <= 16'd1;
    end else begin
      if (per_cnt != 16'hFFFF) per_cnt <= per_cnt + 16'd1;
      if (going_idle)          period  <= 16'hFFFF;
    end
`endif
endmodule

module trackball_quad_decoder #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          FILTER_LEN     = 4,
  parameter logic [19:0] IDLE_TIMEOUT   = 20'd600000,
  parameter int          CLEAR_ON_LATCH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_dir_in,
  input  logic        h_clk_in,
  input  logic        v_dir_in,
  input  logic        v_clk_in,
  input  logic        latch,
  output logic [7:0]  h_count,
  output logic [7:0]  v_count,
  output logic        h_step,
  output logic        v_step,
  output logic        h_active,
  output logic        v_active
`ifdef TRACKBALL_PERIOD_EN
  ,
  output logic [15:0] h_period,
  output logic [15:0] v_period
`endif
);
  // Lane order: {v_clk, v_dir, h_clk, h_dir}; axis 0 = h, axis 1 = v.
  logic [3:0]      raw, filt;
  logic [1:0][7:0] count;
  logic [1:0]      step, active;
`ifdef TRACKBALL_PERIOD_EN
  logic [1:0][15:0] period;
`endif

  assign raw = {v_clk_in, v_dir_in, h_clk_in, h_dir_in};

  for (genvar i = 0; i < 4; i++) begin : g_in
    trackball_qd_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_filt (
      .clk  (clk),
      .reset(reset),
      .d    (raw[i]),
      .q    (filt[i])
    );
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    trackball_qd_axis #(
      .IDLE_TIMEOUT  (IDLE_TIMEOUT),
      .CLEAR_ON_LATCH(CLEAR_ON_LATCH)
    ) u_axis (
      .clk   (clk),
      .reset (reset),
      .dir_f (filt[2*a]),
      .clk_f (filt[2*a+1]),
      .latch (latch),
      .count (count[a]),
      .step  (step[a]),
      .active(active[a])
`ifdef TRACKBALL_PERIOD_EN
      ,
      .period(period[a])
`endif
    );
  end

  assign h_count  = count[0];
  assign v_count  = count[1];
  assign h_step   = step[0];
  assign v_step   = step[1];
  assign h_active = active[0];
  assign v_active = active[1];
`ifdef TRACKBALL_PERIOD_EN
  assign h_period = period[0];
  assign v_period = period[1];
`endif
endmodule
